// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the P7 inter-stage pipeline registers:
// stage bundle layout, NOP payload, slot states and occupancy width helper.
package cpu_pipe_pkg;

   localparam int unsigned A3_W   = 5;
   localparam int unsigned WORD_W = 32;

   // EXE bundle {A3, ALU_O, DR, PC4, PC8}, PC8 in the least significant word
   localparam int unsigned PC8_LSB      = 0;
   localparam int unsigned PC4_LSB      = PC8_LSB + WORD_W;
   localparam int unsigned DR_LSB       = PC4_LSB + WORD_W;
   localparam int unsigned ALU_O_LSB    = DR_LSB + WORD_W;
   localparam int unsigned A3_LSB       = ALU_O_LSB + WORD_W;
   localparam int unsigned EXE_BUNDLE_W = A3_LSB + A3_W;

   localparam logic [EXE_BUNDLE_W-1:0] NOP_PAYLOAD = '0;

   typedef enum logic [1:0] {
      SLOT_EMPTY = 2'd0,
      SLOT_FULL  = 2'd1,
      SLOT_SKID  = 2'd2
   } slot_state_e;

   function automatic int unsigned OCC_W(input int unsigned depth);
      return $clog2(2 * depth + 1);
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One elastic slot: main register plus a one-entry skid register.
// Upstream ready is a flop, so no combinational path runs from out_ready_i to in_ready_o.
module pipe_slot
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter bit          ZERO_DATA = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [1:0]       count_o
);

   slot_state_e      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             rdy_q, rdy_d;
   logic             accept, drain;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      accept  = in_valid_i & rdy_q;
      drain   = (state_q != SLOT_EMPTY) & out_ready_i;
      unique case (state_q)
         SLOT_EMPTY: begin
            if (accept) begin
               main_d  = in_data_i;
               state_d = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (accept && drain) begin
               main_d = in_data_i;
            end else if (accept) begin
               skid_d  = in_data_i;
               state_d = SLOT_SKID;
            end else if (drain) begin
               state_d = SLOT_EMPTY;
               if (ZERO_DATA) main_d = '0;
            end
         end
         SLOT_SKID: begin
            if (drain) begin
               main_d  = skid_q;
               state_d = SLOT_FULL;
               if (ZERO_DATA) skid_d = '0;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
      if (flush_i) begin
         state_d = SLOT_EMPTY;
         if (ZERO_DATA) begin
            main_d = '0;
            skid_d = '0;
         end
      end
      // ready follows the next state so it is already a flop output next cycle
      rdy_d = (state_d != SLOT_SKID);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SLOT_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= rdy_d;
      end
   end

   assign in_ready_o  = rdy_q;
   assign out_valid_o = (state_q != SLOT_EMPTY);
   assign out_data_o  = main_q;
   assign count_o     = (state_q == SLOT_SKID) ? 2'd2 :
                        (state_q == SLOT_FULL) ? 2'd1 : 2'd0;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Flushable inter-stage pipeline register: DEPTH chained skid slots
// with an entry-occupancy counter.
module elastic_pipe_reg
   import cpu_pipe_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 1,
   parameter bit          ZERO_DATA = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [OCC_W(DEPTH)-1:0]   occupancy
);

   localparam int unsigned OW = OCC_W(DEPTH);

   logic [DEPTH:0]   v;
   logic [DEPTH:0]   r;
   logic [WIDTH-1:0] d   [DEPTH+1];
   logic [1:0]       cnt [DEPTH];

   assign v[0]      = in_valid;
   assign d[0]      = in_data;
   assign in_ready  = r[0];
   assign out_valid = v[DEPTH];
   assign out_data  = d[DEPTH];
   assign r[DEPTH]  = out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      pipe_slot #(
         .WIDTH     (WIDTH),
         .ZERO_DATA (ZERO_DATA)
      ) u_slot (
         .clk_i       (clk),
         .rst_i       (reset),
         .flush_i     (flush),
         .in_valid_i  (v[i]),
         .in_ready_o  (r[i]),
         .in_data_i   (d[i]),
         .out_valid_o (v[i+1]),
         .out_ready_i (r[i+1]),
         .out_data_o  (d[i+1]),
         .count_o     (cnt[i])
      );
   end

   logic [OW-1:0] occ_q, occ_d;
   logic          in_xfer, out_xfer;

   always_comb begin
      in_xfer  = in_valid & in_ready;
      out_xfer = out_valid & out_ready;
      occ_d    = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (in_xfer && !out_xfer) begin
         occ_d = occ_q + OW'(1);
      end else if (!in_xfer && out_xfer) begin
         occ_d = occ_q - OW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) occ_q <= '0;
      else       occ_q <= occ_d;
   end

   assign occupancy = occ_q;

   logic [OW-1:0] slot_sum;
   always_comb begin
      slot_sum = '0;
      for (int unsigned k = 0; k < DEPTH; k++) slot_sum = slot_sum + OW'(cnt[k]);
   end

   a_occ_matches_slots: assert property (@(posedge clk) disable iff (reset) occ_q == slot_sum);

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: three instances (DEPTH 1/2/3) checked with
// directed scenarios and a queue-based reference model under random traffic.
module tb_elastic_pipe_reg;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush     [3];
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [W-1:0] in_data   [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [W-1:0] out_data  [3];
   logic [1:0]   occ1;
   logic [2:0]   occ2, occ3;
   logic [3:0]   occ       [3];
   int           tests = 0;
   int           fails = 0;

   always #5 clk = ~clk;

   assign occ[0] = {2'b00, occ1};
   assign occ[1] = {1'b0, occ2};
   assign occ[2] = {1'b0, occ3};

   elastic_pipe_reg #(.WIDTH(W), .DEPTH(1), .ZERO_DATA(1'b1)) u_d1 (
      .clk(clk), .reset(reset), .flush(flush[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .occupancy(occ1));
   elastic_pipe_reg #(.WIDTH(W), .DEPTH(2), .ZERO_DATA(1'b1)) u_d2 (
      .clk(clk), .reset(reset), .flush(flush[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .occupancy(occ2));
   elastic_pipe_reg #(.WIDTH(W), .DEPTH(3), .ZERO_DATA(1'b1)) u_d3 (
      .clk(clk), .reset(reset), .flush(flush[2]),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
      .occupancy(occ3));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int k = 0; k < 3; k++) begin
         flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = '0;
      end
   endtask

   task automatic do_reset();
      idle_all();
      #2 reset = 1'b1;
      cyc(); cyc();
      #2 reset = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b1; in_data[k] = 16'(16'h1234 + k);
      end
      cyc(); cyc();
      for (int k = 0; k < 3; k++) in_valid[k] = 1'b0;
      #3 reset = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         tests++; if (out_valid[k] !== 1'b0) begin fails++; $display("FAIL rst_out_valid[%0d]: got %b want 0", k, out_valid[k]); end
         tests++; if (out_data[k] !== '0) begin fails++; $display("FAIL rst_out_data[%0d]: got %h want 0", k, out_data[k]); end
         tests++; if (occ[k] !== 4'd0) begin fails++; $display("FAIL rst_occ[%0d]: got %0d want 0", k, occ[k]); end
         tests++; if (in_ready[k] !== 1'b0) begin fails++; $display("FAIL rst_in_ready[%0d]: got %b want 0", k, in_ready[k]); end
      end
      cyc();
      tests++; if (in_ready[0] !== 1'b0) begin fails++; $display("FAIL rst_held_ready: got %b want 0", in_ready[0]); end
      #3 reset = 1'b0;
      #1;
      tests++; if (in_ready[1] !== 1'b0) begin fails++; $display("FAIL rst_release_ready: got %b want 0", in_ready[1]); end
      cyc();
      for (int k = 0; k < 3; k++) begin
         tests++; if (in_ready[k] !== 1'b1) begin fails++; $display("FAIL rst_ready_after[%0d]: got %b want 1", k, in_ready[k]); end
      end
   endtask

   task automatic test_stream();
      int acc, del;
      logic exp_v;
      logic [W-1:0] exp_d;
      do_reset();
      out_ready[2] = 1'b1;
      for (int c = 0; c < 13; c++) begin
         in_valid[2] = (c < 8);
         in_data[2]  = (c < 8) ? 16'(c + 1) : '0;
         acc   = (c < 8) ? c : 8;
         del   = (c < 3) ? 0 : ((c - 3 > 8) ? 8 : c - 3);
         exp_v = (c >= 3) && (c < 11);
         exp_d = exp_v ? 16'(c - 2) : '0;
         #2;
         tests++; if (out_valid[2] !== exp_v) begin fails++; $display("FAIL stream_valid c%0d: got %b want %b", c, out_valid[2], exp_v); end
         tests++; if (out_data[2] !== exp_d) begin fails++; $display("FAIL stream_data c%0d: got %h want %h", c, out_data[2], exp_d); end
         tests++; if (occ[2] !== 4'(acc - del)) begin fails++; $display("FAIL stream_occ c%0d: got %0d want %0d", c, occ[2], acc - del); end
         if (c < 8) begin
            tests++; if (in_ready[2] !== 1'b1) begin fails++; $display("FAIL stream_ready c%0d: got %b want 1", c, in_ready[2]); end
         end
         cyc();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid[0] = 1'b1; in_data[0] = 16'h000A;
      #2;
      tests++; if (in_ready[0] !== 1'b1) begin fails++; $display("FAIL bp_ready0: got %b want 1", in_ready[0]); end
      cyc();
      in_data[0] = 16'h000B;
      #2;
      tests++; if (in_ready[0] !== 1'b1) begin fails++; $display("FAIL bp_ready1: got %b want 1", in_ready[0]); end
      tests++; if (out_data[0] !== 16'h000A) begin fails++; $display("FAIL bp_head1: got %h want 000a", out_data[0]); end
      tests++; if (occ[0] !== 4'd1) begin fails++; $display("FAIL bp_occ1: got %0d want 1", occ[0]); end
      cyc();
      in_data[0] = 16'h000C;
      for (int c = 0; c < 2; c++) begin
         #2;
         tests++; if (in_ready[0] !== 1'b0) begin fails++; $display("FAIL bp_stalled c%0d: got %b want 0", c, in_ready[0]); end
         tests++; if (occ[0] !== 4'd2) begin fails++; $display("FAIL bp_occ2 c%0d: got %0d want 2", c, occ[0]); end
         tests++; if (out_data[0] !== 16'h000A) begin fails++; $display("FAIL bp_hold c%0d: got %h want 000a", c, out_data[0]); end
         cyc();
      end
      out_ready[0] = 1'b1;
      #2;
      tests++; if (out_valid[0] !== 1'b1 || out_data[0] !== 16'h000A) begin fails++; $display("FAIL bp_outA: got %b/%h want 1/000a", out_valid[0], out_data[0]); end
      tests++; if (in_ready[0] !== 1'b0) begin fails++; $display("FAIL bp_readyA: got %b want 0", in_ready[0]); end
      cyc();
      #2;
      tests++; if (out_valid[0] !== 1'b1 || out_data[0] !== 16'h000B) begin fails++; $display("FAIL bp_outB: got %b/%h want 1/000b", out_valid[0], out_data[0]); end
      tests++; if (in_ready[0] !== 1'b1) begin fails++; $display("FAIL bp_readyB: got %b want 1", in_ready[0]); end
      cyc();
      in_valid[0] = 1'b0;
      #2;
      tests++; if (out_valid[0] !== 1'b1 || out_data[0] !== 16'h000C) begin fails++; $display("FAIL bp_outC: got %b/%h want 1/000c", out_valid[0], out_data[0]); end
      tests++; if (occ[0] !== 4'd1) begin fails++; $display("FAIL bp_occC: got %0d want 1", occ[0]); end
      cyc();
      #2;
      tests++; if (out_valid[0] !== 1'b0 || occ[0] !== 4'd0) begin fails++; $display("FAIL bp_empty: got %b/%0d want 0/0", out_valid[0], occ[0]); end
   endtask

   task automatic test_flush();
      int acc = 0;
      do_reset();
      for (int c = 0; c < 20 && acc < 4; c++) begin
         in_valid[1] = 1'b1; in_data[1] = 16'(acc + 1);
         #2;
         if (in_ready[1] === 1'b1) acc++;
         cyc();
      end
      in_valid[1] = 1'b0;
      #2;
      tests++; if (acc != 4 || occ[1] !== 4'd4) begin fails++; $display("FAIL flush_fill: accepted %0d occ %0d want 4/4", acc, occ[1]); end
      in_valid[1] = 1'b1; in_data[1] = 16'hDEAD; flush[1] = 1'b1;
      cyc();
      in_valid[1] = 1'b0; flush[1] = 1'b0;
      #2;
      tests++; if (out_valid[1] !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", out_valid[1]); end
      tests++; if (out_data[1] !== '0) begin fails++; $display("FAIL flush_data: got %h want 0", out_data[1]); end
      tests++; if (occ[1] !== 4'd0) begin fails++; $display("FAIL flush_occ: got %0d want 0", occ[1]); end
      tests++; if (in_ready[1] !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b want 1", in_ready[1]); end
      out_ready[1] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cyc();
         #2;
         tests++; if (out_valid[1] !== 1'b0 || out_data[1] === 16'hDEAD) begin fails++; $display("FAIL flush_ghost c%0d: got %b/%h want 0/0000", c, out_valid[1], out_data[1]); end
      end
   endtask

   task automatic test_flush_head();
      do_reset();
      in_valid[0] = 1'b1; in_data[0] = 16'h0055;
      cyc();
      in_valid[0] = 1'b0;
      #2;
      flush[0] = 1'b1; out_ready[0] = 1'b1;
      #1;
      tests++; if (out_valid[0] !== 1'b1 || out_data[0] !== 16'h0055) begin fails++; $display("FAIL fhead_deliver: got %b/%h want 1/0055", out_valid[0], out_data[0]); end
      cyc();
      flush[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2;
         tests++; if (out_valid[0] !== 1'b0 || occ[0] !== 4'd0) begin fails++; $display("FAIL fhead_after c%0d: got %b/%0d want 0/0", c, out_valid[0], occ[0]); end
         cyc();
      end
   endtask

   task automatic test_random(input int k);
      logic [W-1:0] q[$];
      logic [W-1:0] exp;
      int delivered = 0;
      do_reset();
      for (int c = 0; c < 3400; c++) begin
         if (c < 3300) begin
            in_valid[k]  = ($urandom_range(0, 3) != 0);
            in_data[k]   = 16'($urandom);
            out_ready[k] = ($urandom_range(0, 2) != 0);
            flush[k]     = ($urandom_range(0, 99) == 0);
         end else begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b1; flush[k] = 1'b0;
         end
         #2;
         tests++; if ($isunknown({in_ready[k], out_valid[k], out_data[k], occ[k]})) begin fails++; $display("FAIL rnd_x[%0d] c%0d: got %b/%b/%h/%0d want no X", k, c, in_ready[k], out_valid[k], out_data[k], occ[k]); end
         tests++; if (occ[k] !== 4'(q.size())) begin fails++; $display("FAIL rnd_occ[%0d] c%0d: got %0d want %0d", k, c, occ[k], q.size()); end
         if (out_valid[k] !== 1'b1) begin
            tests++; if (out_data[k] !== '0) begin fails++; $display("FAIL rnd_idle_data[%0d] c%0d: got %h want 0", k, c, out_data[k]); end
         end else if (out_ready[k]) begin
            tests++;
            if (q.size() == 0) begin
               fails++; $display("FAIL rnd_extra[%0d] c%0d: got %h want nothing", k, c, out_data[k]);
            end else begin
               exp = q.pop_front();
               delivered++;
               if (out_data[k] !== exp) begin fails++; $display("FAIL rnd_order[%0d] c%0d: got %h want %h", k, c, out_data[k], exp); end
            end
         end
         if (flush[k]) q.delete();
         else if (in_valid[k] && in_ready[k] === 1'b1) q.push_back(in_data[k]);
         cyc();
      end
      tests++; if (q.size() != 0) begin fails++; $display("FAIL rnd_drain[%0d]: got %0d left want 0", k, q.size()); end
      tests++; if (delivered < 500) begin fails++; $display("FAIL rnd_progress[%0d]: got %0d delivered want >=500", k, delivered); end
   endtask

   initial begin
      reset = 1'b1;
      idle_all();
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_flush_head();
      for (int k = 0; k < 3; k++) test_random(k);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
